// File: rtl/game_pkg.sv
// Shared encodings for the NOT NOT round sequencer: FSM states, key width,
// direction codes and the prompt-to-target mapping.
package game_pkg;

    localparam int KEY_W   = 16;
    localparam int NOT_BIT = 2;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PROMPT    = 3'd1,
        WAIT      = 3'd2,
        JUDGE     = 3'd3,
        RESULT    = 3'd4,
        RELEASE   = 3'd5,
        GAME_OVER = 3'd6
    } state_t;

    // NOT flips up<->down and left<->right, which is just bit 0 of the direction.
    function automatic logic [1:0] target_dir(input logic [2:0] p);
        return p[NOT_BIT] ? (p[1:0] ^ 2'b01) : p[1:0];
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake bundle between the round sequencer and the key/display side.
// slave = the sequencer, master = whatever drives start and the keys.
interface round_sequencer_if #(
    parameter int SCORE_W = 8
);
    logic                       start;
    logic                       key_pressed;
    logic [game_pkg::KEY_W-1:0] user_input;
    logic [2:0]                 prompt;
    logic                       prepare_judge;
    logic                       round_active;
    logic                       correct;
    logic                       wrong;
    logic                       timed_out;
    logic [SCORE_W-1:0]         score;
    logic [3:0]                 lives_left;
    logic                       game_over;

    modport slave (
        input  start, key_pressed, user_input,
        output prompt, prepare_judge, round_active, correct, wrong,
               timed_out, score, lives_left, game_over
    );

    modport master (
        output start, key_pressed, user_input,
        input  prompt, prepare_judge, round_active, correct, wrong,
               timed_out, score, lives_left, game_over
    );
endinterface

// File: rtl/prompt_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) used as prompt source.
module prompt_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);
    localparam logic [15:0] TAPS = 16'hB400;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= SEED;
        else       q <= {1'b0, q[15:1]} ^ (q[0] ? TAPS : 16'h0000);
    end
endmodule

// File: rtl/round_sequencer.sv
// NOT NOT round controller: presents a prompt, waits for a key or timeout,
// scores the answer and tracks score/lives until game over.
module round_sequencer
    import game_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 50_000_000,
    parameter int          LIVES          = 3,
    parameter int          SCORE_W        = 8,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input logic              clk,
    input logic              reset,
    round_sequencer_if.slave bus
);
    localparam int          TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LIVES_INIT = 4'(LIVES);

    state_t             state, state_n;
    logic [TW-1:0]      timer;
    logic [2:0]         prompt_q;
    logic [KEY_W-1:0]   key_q;
    logic [SCORE_W-1:0] score_q;
    logic [3:0]         lives_q;
    logic               pj_q, correct_q, wrong_q, timeout_q;
    logic [15:0]        lfsr_q;
    logic               unused_lfsr;
    logic               hit, expire, win, lose;

    prompt_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );
    assign unused_lfsr = ^lfsr_q[15:3];

    // Exact one-hot match: chords and empty codes can never hit.
    assign hit    = (key_q == (KEY_W'(1) << target_dir(prompt_q)));
    assign expire = (state == WAIT) && !bus.key_pressed && (timer == '0);
    assign win    = (state == JUDGE) && hit;
    assign lose   = ((state == JUDGE) && !hit) || expire;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (bus.start) state_n = PROMPT;
            PROMPT:    state_n = WAIT;
            WAIT: begin
                if (bus.key_pressed)  state_n = JUDGE;
                else if (timer == '0) state_n = RESULT;
            end
            JUDGE:     state_n = RESULT;
            RESULT:    state_n = RELEASE;
            RELEASE: begin
                if (!bus.key_pressed) state_n = (lives_q == '0) ? GAME_OVER : PROMPT;
            end
            GAME_OVER: if (bus.start) state_n = PROMPT;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            prompt_q  <= '0;
            key_q     <= '0;
            score_q   <= '0;
            lives_q   <= LIVES_INIT;
            pj_q      <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            // Pulses are registered so they line up with the prompt / counter updates.
            pj_q      <= (state == PROMPT);
            correct_q <= win;
            wrong_q   <= lose;
            timeout_q <= expire;

            if (state == PROMPT) begin
                prompt_q <= lfsr_q[2:0];
                timer    <= TIMER_LOAD;
            end

            if (state == WAIT) begin
                if (bus.key_pressed) key_q <= bus.user_input;
                else if (timer != '0) timer <= timer - 1'b1;
            end

            if (state == GAME_OVER && bus.start) begin
                score_q <= '0;
                lives_q <= LIVES_INIT;
            end else begin
                if (win && score_q != '1)  score_q <= score_q + 1'b1;
                if (lose && lives_q != '0) lives_q <= lives_q - 1'b1;
            end
        end
    end

    assign bus.prompt        = prompt_q;
    assign bus.prepare_judge = pj_q;
    assign bus.round_active  = (state == PROMPT) || (state == WAIT) || (state == JUDGE);
    assign bus.correct       = correct_q;
    assign bus.wrong         = wrong_q;
    assign bus.timed_out     = timeout_q;
    assign bus.score         = score_q;
    assign bus.lives_left    = lives_q;
    assign bus.game_over     = (state == GAME_OVER);

endmodule
